// File: rtl/buyruk_hizalama_kuyrugu.sv
// Fetch queue: stores 32-bit fetch words and re-aligns them into 16-bit (RVC) and 32-bit
// instructions tagged with their PC; drops stale fetch responses that follow a flush.
module buyruk_hizalama_kuyrugu #(
    parameter int unsigned        DERINLIK     = 4,
    parameter int unsigned        PS_BIT       = 32,
    parameter logic [PS_BIT-1:0]  BASLANGIC_PS = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 yaz_gecerli_i,
    output logic                                 yaz_hazir_o,
    input  logic [31:0]                          yaz_buyruk_i,
    input  logic [PS_BIT-1:0]                    yaz_adres_i,
    input  logic                                 bosalt_i,
    input  logic [PS_BIT-1:0]                    bosalt_adres_i,
    output logic                                 oku_gecerli_o,
    input  logic                                 oku_hazir_i,
    output logic [31:0]                          oku_buyruk_o,
    output logic [PS_BIT-1:0]                    oku_ps_o,
    output logic                                 oku_sikistirilmis_o,
    output logic [$clog2(2*DERINLIK):0]          doluluk_o
);
    localparam int unsigned AW = $clog2(DERINLIK);
    localparam int unsigned CW = $clog2(2*DERINLIK) + 1;
    localparam int unsigned WA = PS_BIT - 2;

    logic [31:0]        bellek [DERINLIK];
    logic [AW:0]        yaz_isr;
    logic [AW:0]        oku_isr;
    logic               ofset;
    logic               ilk;
    logic [WA-1:0]      beklenen;
    logic [PS_BIT-1:0]  bas_ps;
    logic [CW-1:0]      sayac;

    logic [AW-1:0]      oku_idx;
    logic [AW-1:0]      sonraki_idx;
    logic [AW:0]        dolu_slot;
    logic [15:0]        h0;
    logic [15:0]        h1;
    logic               rvc;
    logic               gecerli;
    logic               okuma;
    logic               yazma;
    logic               kabul;
    logic [1:0]         adim;
    logic [CW-1:0]      ekle;
    logic [CW-1:0]      cikar;
    logic [AW+1:0]      yeni_konum;

    // Head/next halfword selection; the next halfword may live in the following slot.
    always_comb begin
        oku_idx     = oku_isr[AW-1:0];
        sonraki_idx = oku_idx + AW'(1);
        dolu_slot   = yaz_isr - oku_isr;
        h0          = ofset ? bellek[oku_idx][31:16]    : bellek[oku_idx][15:0];
        h1          = ofset ? bellek[sonraki_idx][15:0] : bellek[oku_idx][31:16];
        rvc         = (h0[1:0] != 2'b11);
        gecerli     = rvc ? (sayac >= CW'(1)) : (sayac >= CW'(2));
        adim        = rvc ? 2'd1 : 2'd2;
        yaz_hazir_o = (dolu_slot < (AW+1)'(DERINLIK));
        okuma       = gecerli & oku_hazir_i & ~bosalt_i;
        yazma       = yaz_gecerli_i & yaz_hazir_o & ~bosalt_i;
        kabul       = yazma & ((yaz_adres_i >> 2) == {2'b00, beklenen});
        ekle        = '0;
        if (kabul) ekle = (ilk & ofset) ? CW'(1) : CW'(2);
        cikar       = okuma ? CW'(adim) : '0;
        yeni_konum  = {oku_isr, ofset} + (AW+2)'(adim);
    end

    always_comb begin
        oku_gecerli_o       = gecerli;
        oku_buyruk_o        = '0;
        oku_ps_o            = '0;
        oku_sikistirilmis_o = 1'b0;
        doluluk_o           = sayac;
        if (gecerli) begin
            oku_buyruk_o        = rvc ? {16'h0000, h0} : {h1, h0};
            oku_ps_o            = bas_ps;
            oku_sikistirilmis_o = rvc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (kabul) bellek[yaz_isr[AW-1:0]] <= yaz_buyruk_i;
    end

    // Pointer, count and expected-address bookkeeping; flush wins over read and write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_isr  <= '0;
            oku_isr  <= '0;
            ofset    <= BASLANGIC_PS[1];
            ilk      <= 1'b1;
            beklenen <= BASLANGIC_PS[PS_BIT-1:2];
            bas_ps   <= {BASLANGIC_PS[PS_BIT-1:1], 1'b0};
            sayac    <= '0;
        end else if (bosalt_i) begin
            yaz_isr  <= '0;
            oku_isr  <= '0;
            ofset    <= bosalt_adres_i[1];
            ilk      <= 1'b1;
            beklenen <= WA'(bosalt_adres_i >> 2);
            bas_ps   <= bosalt_adres_i & ~PS_BIT'(1);
            sayac    <= '0;
        end else begin
            if (kabul) begin
                yaz_isr  <= yaz_isr + (AW+1)'(1);
                beklenen <= beklenen + WA'(1);
                ilk      <= 1'b0;
            end
            if (okuma) begin
                {oku_isr, ofset} <= yeni_konum;
                bas_ps           <= bas_ps + PS_BIT'({adim, 1'b0});
            end
            sayac <= sayac + ekle - cikar;
        end
    end
endmodule

// File: tb/tb_buyruk_hizalama_kuyrugu.sv
// Scoreboard bench for buyruk_hizalama_kuyrugu: a halfword-stream reference model predicts
// the instruction sequence; a monitor compares every issued instruction and the queue status.
module tb_buyruk_hizalama_kuyrugu;
    localparam int unsigned DER = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        yaz_gecerli = 1'b0;
    logic        yaz_hazir;
    logic [31:0] yaz_buyruk = '0;
    logic [31:0] yaz_adres = '0;
    logic        bosalt = 1'b0;
    logic [31:0] bosalt_adres = '0;
    logic        oku_gecerli;
    logic        oku_hazir = 1'b0;
    logic [31:0] oku_buyruk;
    logic [31:0] oku_ps;
    logic        oku_sik;
    logic [3:0]  doluluk;

    always #5 clk = ~clk;

    buyruk_hizalama_kuyrugu #(.DERINLIK(DER), .PS_BIT(32), .BASLANGIC_PS(32'h0)) dut (
        .clk_i(clk), .rst_i(rst),
        .yaz_gecerli_i(yaz_gecerli), .yaz_hazir_o(yaz_hazir),
        .yaz_buyruk_i(yaz_buyruk), .yaz_adres_i(yaz_adres),
        .bosalt_i(bosalt), .bosalt_adres_i(bosalt_adres),
        .oku_gecerli_o(oku_gecerli), .oku_hazir_i(oku_hazir),
        .oku_buyruk_o(oku_buyruk), .oku_ps_o(oku_ps),
        .oku_sikistirilmis_o(oku_sik), .doluluk_o(doluluk)
    );

    typedef struct { logic [15:0] h; logic [31:0] pc; } hw_t;
    typedef struct { logic [31:0] ins; logic [31:0] pc; logic sik; } ins_t;

    hw_t         pend[$];
    ins_t        exp_q[$];
    int          slot_q[$];
    int          mcount;
    logic [29:0] exp_wa;
    logic        first;
    logic        start_off;
    int          tests = 0;
    int          fails = 0;
    logic        last_acc;
    logic [29:0] fetch_wa;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void model_reset(input logic [31:0] pcs);
        pend.delete(); exp_q.delete(); slot_q.delete();
        mcount = 0; exp_wa = pcs[31:2]; first = 1'b1; start_off = pcs[1];
    endfunction

    // Append a fetched word as halfwords, then assemble every complete instruction.
    function automatic void model_push(input logic [31:0] d);
        hw_t  a, b;
        ins_t e;
        a.h = d[15:0];  a.pc = {exp_wa, 2'b00};
        b.h = d[31:16]; b.pc = {exp_wa, 2'b10};
        if (first && start_off) begin
            pend.push_back(b); slot_q.push_back(1); mcount += 1;
        end else begin
            pend.push_back(a); pend.push_back(b); slot_q.push_back(2); mcount += 2;
        end
        first = 1'b0;
        exp_wa = exp_wa + 30'd1;
        while (pend.size() > 0) begin
            if (pend[0].h[1:0] != 2'b11) begin
                e.ins = {16'h0, pend[0].h}; e.pc = pend[0].pc; e.sik = 1'b1;
                void'(pend.pop_front());
            end else if (pend.size() >= 2) begin
                e.ins = {pend[1].h, pend[0].h}; e.pc = pend[0].pc; e.sik = 1'b0;
                void'(pend.pop_front()); void'(pend.pop_front());
            end else break;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void model_consume(input int n);
        mcount -= n;
        for (int k = 0; k < n; k++) begin
            if (slot_q.size() > 0) begin
                slot_q[0] = slot_q[0] - 1;
                if (slot_q[0] == 0) void'(slot_q.pop_front());
            end
        end
    endfunction

    // One clock of stimulus; the model absorbs the write/flush just after the edge.
    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic fl, input logic [31:0] fa, input logic r);
        logic acc;
        @(negedge clk);
        yaz_gecerli = v; yaz_adres = a; yaz_buyruk = d;
        bosalt = fl; bosalt_adres = fa; oku_hazir = r;
        #1;
        acc = v && (slot_q.size() < DER) && !fl;
        @(posedge clk); #1;
        if (fl) model_reset(fa);
        else if (acc && a[31:2] == exp_wa) model_push(d);
        last_acc = acc;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1; yaz_gecerli = 0; bosalt = 0; oku_hazir = 0;
        #1 model_reset(32'h0);
        @(negedge clk);
        rst = 1'b0;
        fetch_wa = '0;
    endtask

    // Monitor: status every cycle, instruction contents whenever a read fires.
    initial begin
        ins_t e;
        forever begin
            @(negedge clk); #2;
            chk("oku_gecerli", 32'(oku_gecerli), 32'(exp_q.size() > 0));
            chk("doluluk", 32'(doluluk), 32'(mcount));
            chk("yaz_hazir", 32'(yaz_hazir), 32'(slot_q.size() < DER));
            if (oku_gecerli && oku_hazir && !bosalt && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 32'(oku_gecerli), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("oku_buyruk", oku_buyruk, e.ins);
                    chk("oku_ps", oku_ps, e.pc);
                    chk("oku_sik", 32'(oku_sik), 32'(e.sik));
                    model_consume(e.sik ? 1 : 2);
                end
            end
        end
    end

    initial begin
        logic [31:0] fa, a, d;
        logic        fl, v, r, stale;
        model_reset(32'h0);
        fetch_wa = '0;
        @(negedge clk); #3;
        chk("reset_buyruk", oku_buyruk, 32'h0);
        chk("reset_ps", oku_ps, 32'h0);
        chk("reset_sik", 32'(oku_sik), 32'h0);
        chk("reset_hazir", 32'(yaz_hazir), 32'h1);
        rst = 1'b0;

        // aligned 32-bit stream
        cyc(1, 32'h0, 32'h0000_0013, 0, 0, 0);
        cyc(1, 32'h4, 32'h0010_0093, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        // RVC pair
        rst_pulse();
        cyc(1, 32'h0, 32'h0085_4501, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        // straddle
        rst_pulse();
        cyc(1, 32'h0, 32'h0093_4501, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 32'h4, 32'hABCD_0010, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        // flush to odd halfword while holding data; flush-cycle write is dropped
        cyc(1, 32'h8, 32'h0000_0013, 0, 0, 0);
        cyc(1, 32'hC, 32'h1111_1113, 1, 32'h102, 0);
        cyc(1, 32'h100, 32'h4501_0093, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        // stale drop after flush to 0x200
        cyc(0, 0, 0, 1, 32'h200, 0);
        cyc(1, 32'h80, 32'h0000_0013, 0, 0, 0);
        cyc(1, 32'h200, 32'h0020_0113, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 1);
        // full/backpressure: five sequential words, reader stalled then released
        rst_pulse();
        for (int i = 0; i < 20; i++) begin
            r = (i >= 7);
            if (fetch_wa < 30'd5) begin
                cyc(1, {fetch_wa, 2'b00}, 32'h0000_0013 | (32'(fetch_wa) << 20), 0, 0, r);
                if (last_acc) fetch_wa = fetch_wa + 30'd1;
            end else cyc(0, 0, 0, 0, 0, r);
        end

        // randomized traffic with flushes, stale responses, PC wrap and mid-run resets
        rst_pulse();
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) rst_pulse();
            fl = ($urandom % 40 == 0);
            if ($urandom % 4 == 0) fa = 32'hFFFF_FFF0 + 32'(($urandom % 8) * 2);
            else fa = 32'(($urandom % 2048) * 2);
            v = ($urandom % 4 != 0);
            stale = ($urandom % 8 == 0);
            if (stale) a = {fetch_wa - 30'(1 + $urandom % 3), 2'($urandom)};
            else a = {fetch_wa, 2'($urandom)};
            d = $urandom;
            r = ($urandom % 10 < 7);
            cyc(v, a, d, fl, fa, r);
            if (fl) fetch_wa = fa[31:2];
            else if (last_acc && !stale) fetch_wa = fetch_wa + 30'd1;
        end
        repeat (12) cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk); #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
